// File: rtl/tlut_simd_engine.sv
// Temporal-LUT SIMD multiplier: products built by repeated weight addition,
// each lane latching the running sum while the counter is below its input.
module tlut_simd_engine #(
  parameter int DIM_A        = 32,
  parameter int DIM_C        = 4,
  parameter int INPUT_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = INPUT_WIDTH + WEIGHT_WIDTH,
  parameter int EARLY_TERM   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DIM_A-1:0][INPUT_WIDTH-1:0] input_bin,
  input  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] weight_bin,
  output logic out_valid,
  input  logic out_ready,
  output logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] product,
  output logic [INPUT_WIDTH:0] run_cycles,
  output logic busy
);

  localparam int CW = INPUT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;
  logic [DIM_A-1:0][INPUT_WIDTH-1:0] in_q, in_d;
  logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] w_q, w_d;
  logic [DIM_C-1:0][ACC_WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] limit_q, limit_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] max_in, limit_new, cnt_inc;

  always_comb begin
    max_in = '0;
    for (int a = 0; a < DIM_A; a++) begin
      if ({1'b0, input_bin[a]} > max_in) max_in = {1'b0, input_bin[a]};
    end
  end

  // Without early termination every batch sweeps the full input range.
  assign limit_new = (EARLY_TERM != 0) ? max_in : (CW'(1) << INPUT_WIDTH);
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    for (int c = 0; c < DIM_C; c++) begin
      acc_nxt[c] = acc_q[c] + ACC_WIDTH'(w_q[c]);
    end
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    w_d     = w_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = input_bin;
          w_d     = weight_bin;
          prod_d  = '0;
          acc_d   = '0;
          cnt_d   = '0;
          limit_d = limit_new;
          if (limit_new == '0) begin
            state_d = DONE;
            run_d   = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = acc_nxt;
        for (int c = 0; c < DIM_C; c++) begin
          for (int a = 0; a < DIM_A; a++) begin
            if (cnt_q < {1'b0, in_q[a]}) prod_d[c][a] = acc_nxt[c];
          end
        end
        cnt_d = cnt_inc;
        if (cnt_inc == limit_q) begin
          state_d = DONE;
          run_d   = limit_q;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_q    <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      run_q   <= run_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign product    = prod_q;
  assign run_cycles = run_q;

endmodule

// File: tb/tb_tlut_simd_engine.sv
// Directed bench: main engine with early termination plus a small
// full-range instance without it.
module tb_tlut_simd_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0][7:0] input_bin;
  logic [3:0][7:0] weight_bin;
  logic [3:0][31:0][15:0] product;
  logic [8:0] run_cycles;

  logic in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [1:0][7:0] input_bin2;
  logic [0:0][7:0] weight_bin2;
  logic [0:0][1:0][15:0] product2;
  logic [8:0] run_cycles2;

  int ntests = 0;
  int nfail = 0;
  int n;

  int exp_b [4][4] = '{'{6, 0, 10, 2}, '{21, 0, 35, 7},
                       '{0, 0, 0, 0}, '{765, 0, 1275, 255}};

  tlut_simd_engine dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_bin(input_bin), .weight_bin(weight_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .run_cycles(run_cycles), .busy(busy)
  );

  tlut_simd_engine #(
    .DIM_A(2), .DIM_C(1), .EARLY_TERM(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .input_bin(input_bin2), .weight_bin(weight_bin2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .product(product2), .run_cycles(run_cycles2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    input_bin = '0;
    weight_bin = '0;
    in_valid2 = 1'b0;
    out_ready2 = 1'b0;
    input_bin2 = '0;
    weight_bin2 = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prod_zero", product == '0, 1);
    chk("rst_run_cycles", run_cycles, 0);

    // Basic batch
    input_bin[0] = 8'd3;
    input_bin[2] = 8'd5;
    input_bin[3] = 8'd1;
    weight_bin = {8'd255, 8'd0, 8'd7, 8'd2};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    wait_done(n);
    chk("basic_latency", n, 5);
    chk("basic_run_cycles", run_cycles, 5);
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 4; a++) begin
        chk($sformatf("basic_p%0d_%0d", c, a), product[c][a], exp_b[c][a]);
      end
      chk($sformatf("basic_p%0d_31", c), product[c][31], 0);
    end

    // Backpressure with toggling in_valid and new operands
    input_bin = '1;
    weight_bin = '1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_p00", product[0][0], 6);
      chk("bp_p32", product[3][2], 1275);
      chk("bp_run", run_cycles, 5);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);

    // All-zero inputs finish right after the handshake
    input_bin = '0;
    weight_bin = {8'd9, 8'd8, 8'd7, 8'd6};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("zero_out_valid", out_valid, 1);
    chk("zero_run_cycles", run_cycles, 0);
    chk("zero_prod", product == '0, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("zero_idle", in_ready, 1);

    // Reset in the middle of a 5-cycle batch
    input_bin[0] = 8'd5;
    weight_bin = {8'd0, 8'd0, 8'd0, 8'd1};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_p00_k2", product[0][0], 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_prod", product == '0, 1);
    chk("abort_run", run_cycles, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_valid", out_valid, 0);
    end
    input_bin[0] = 8'd4;
    weight_bin = {8'd0, 8'd0, 8'd0, 8'd3};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    chk("after_latency", n, 4);
    chk("after_p00", product[0][0], 12);
    chk("after_p10", product[1][0], 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Full-range sweep without early termination
    input_bin2 = {8'd0, 8'd255};
    weight_bin2 = 8'd255;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 400) begin
      tick();
      n++;
    end
    chk("full_latency", n, 256);
    chk("full_run_cycles", run_cycles2, 256);
    chk("full_p00", product2[0][0], 65025);
    chk("full_p01", product2[0][1], 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
